// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
//   - FSM state encoding (3 bits)
//   - instruction / fetch-address bus widths
//   - core reset polarity
//   - big-endian byte-assembly helper
package inst_rom_loader_pkg;

    // Instruction bus width and fetch address bus width seen by the core.
    localparam int INST_BUS_W      = 32;
    localparam int INST_ADDR_BUS_W = 32;

    // Level that holds the core in reset.
    localparam logic RST_ENABLE = 1'b1;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Shift one byte into the low end of a big-endian accumulator, so that
    // the first byte of a group of four ends up in bits 31:24.
    function automatic logic [31:0] be_shift(input logic [31:0] acc, input logic [7:0] b);
        return {acc[23:0], b};
    endfunction

endpackage

// File: rtl/inst_rom_loader_inst_ram.sv
// Instruction RAM: 2^ADDR_W x DATA_W words, synchronous write, asynchronous
// read. No reset on the array, so it maps onto distributed RAM.
//   clk   - clock
//   we    - write enable
//   waddr - write word index
//   wdata - write data
//   raddr - read word index
//   rdata - read data (combinational; returns the pre-write value during a write)
module inst_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Boot loader + instruction memory. Receives a byte stream
//   [N (4B, big-endian)] [N words (4B each, big-endian)] [XOR checksum (1B)]
// writes the words into instruction RAM, verifies the checksum and then
// releases the core from reset. Fetches are served combinationally in every
// state.
//   clk         - clock
//   rst         - asynchronous active-low reset
//   rx_valid_i  - byte available
//   rx_data_i   - byte value
//   rx_ready_o  - loader accepts a byte (LEN/DATA/CSUM)
//   core_rst_o  - reset to the core, deasserted only in RUN
//   rom_ce_i    - fetch enable
//   rom_addr_i  - fetch byte address (bits 1:0 and above ADDR_W+1 ignored)
//   rom_data_o  - fetched instruction, 0 when rom_ce_i is low
//   load_done_o - image loaded and verified
//   load_err_o  - load failed (sticky until rst)
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_valid_i,
    input  logic [7:0]                 rx_data_i,
    output logic                       rx_ready_o,
    output logic                       core_rst_o,
    input  logic                       rom_ce_i,
    input  logic [INST_ADDR_BUS_W-1:0] rom_addr_i,
    output logic [INST_BUS_W-1:0]      rom_data_o,
    output logic                       load_done_o,
    output logic                       load_err_o
);

    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    state_t                  state_reg, state_next;
    logic [1:0]              byte_cnt_reg;
    logic [31:0]             len_reg;
    logic [31:0]             word_reg;
    logic [ADDR_W:0]         widx_reg;
    logic [7:0]              xor_reg;

    logic                    accept;
    logic                    last_byte;
    logic [31:0]             len_full;
    logic [31:0]             word_full;
    logic                    last_word;
    logic                    ram_we;
    logic [INST_BUS_W-1:0]   ram_rdata;

    assign accept    = rx_valid_i && rx_ready_o;
    assign last_byte = (byte_cnt_reg == 2'd3);
    assign len_full  = be_shift(len_reg, rx_data_i);
    assign word_full = be_shift(word_reg, rx_data_i);
    // widx counts words already written; the word being completed now is
    // number widx+1.
    assign last_word = ((32'(widx_reg) + 32'd1) == len_reg);
    assign ram_we    = (state_reg == ST_DATA) && accept && last_byte;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_LEN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LEN: begin
                if (accept && last_byte) begin
                    if (len_full > MAX_WORDS) begin
                        state_next = ST_ERR;
                    end else if (len_full == 32'd0) begin
                        state_next = ST_CSUM;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept && last_byte && last_word) begin
                    state_next = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_next = (rx_data_i == xor_reg) ? ST_RUN : ST_ERR;
                end
            end
            default: state_next = state_reg;
        endcase
    end

    // Outputs decoded from the registered state only
    always_comb begin
        rx_ready_o  = 1'b0;
        core_rst_o  = RST_ENABLE;
        load_done_o = 1'b0;
        load_err_o  = 1'b0;
        case (state_reg)
            ST_LEN, ST_DATA, ST_CSUM: rx_ready_o = 1'b1;
            ST_RUN: begin
                core_rst_o  = ~RST_ENABLE;
                load_done_o = 1'b1;
            end
            ST_ERR: load_err_o = 1'b1;
            default: ;
        endcase
    end

    // Byte counter, length/word assembly, write index and running XOR
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_reg <= 2'd0;
            len_reg      <= 32'd0;
            word_reg     <= 32'd0;
            widx_reg     <= '0;
            xor_reg      <= 8'd0;
        end else if (accept) begin
            if (state_reg == ST_LEN) begin
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
                len_reg      <= len_full;
                xor_reg      <= xor_reg ^ rx_data_i;
            end else if (state_reg == ST_DATA) begin
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
                word_reg     <= word_full;
                xor_reg      <= xor_reg ^ rx_data_i;
                if (last_byte) begin
                    widx_reg <= widx_reg + 1'b1;
                end
            end
        end
    end

    inst_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (INST_BUS_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (widx_reg[ADDR_W-1:0]),
        .wdata (word_full),
        .raddr (rom_addr_i[ADDR_W+1:2]),
        .rdata (ram_rdata)
    );

    assign rom_data_o = rom_ce_i ? ram_rdata : '0;

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, rom_addr_i[INST_ADDR_BUS_W-1:ADDR_W+2], rom_addr_i[1:0]};

endmodule
